// File: rtl/game_input_ctrl.sv
// Button front-end: 2-FF sync, per-button debounce, press-edge detect and
// priority arbitration into single-cycle game commands. Optional LONG_PRESS_RESET_EN.
module game_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnStart,
  input  logic       btnPause,
  input  logic       btnReset,
  output logic       startGame,
  output logic       pauseGame,
  output logic       resetGame,
  output logic [2:0] btnLevel
);

  typedef enum logic [2:0] {
    CMD_NONE  = 3'b000,
    CMD_START = 3'b001,
    CMD_PAUSE = 3'b010,
    CMD_RESET = 3'b100
  } cmd_e;

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    RAW_IDLE = ACTIVE_LOW ? 3'b111 : 3'b000;

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("game_input_ctrl: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  // Bit order everywhere: {reset, pause, start}
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    btn_s;
  logic [2:0]    stable;
  logic [2:0]    stable_q;
  logic [2:0]    press;
  logic [CW-1:0] cnt [3];
  logic          long_evt;
  cmd_e          cmd;

  assign raw = {btnReset, btnPause, btnStart};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign btn_s = ACTIVE_LOW ? ~sync2 : sync2;

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any agreeing sample restarts the window, so cnt never wraps.
  // NOTE: the counter array is plain flops, so it is reset like any register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (btn_s[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= btn_s[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_q <= '0;
    else       stable_q <= stable;
  end

  assign press = stable & ~stable_q;

`ifdef LONG_PRESS_RESET_EN
  localparam int            HW       = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          long_done;

  // Saturates at HOLD_MAX; long_done blocks a second fire within one hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else if (!stable[0]) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HW'(1);
    end else begin
      long_done <= 1'b1;
    end
  end

  assign long_evt = stable[0] & ~long_done & (hold_cnt == HOLD_MAX);
`else
  assign long_evt = 1'b0;
`endif

  // Lower-priority presses on the same edge are dropped, not deferred.
  // NOTE: cmd gets a default before any branch so no latch is inferred.
  always_comb begin
    cmd = CMD_NONE;
    if (press[2] || long_evt) cmd = CMD_RESET;
    else if (press[1])        cmd = CMD_PAUSE;
    else if (press[0])        cmd = CMD_START;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      startGame <= 1'b0;
      pauseGame <= 1'b0;
      resetGame <= 1'b0;
    end else begin
      startGame <= (cmd == CMD_START);
      pauseGame <= (cmd == CMD_PAUSE);
      resetGame <= (cmd == CMD_RESET);
    end
  end

  assign btnLevel = stable;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Scoreboard bench for game_input_ctrl: expected pulses (command, cycle) are
// queued when a button is driven and matched when the DUT emits a pulse.
module tb_game_input_ctrl;

  localparam int DB = 4;
  localparam int LC = 20;

  typedef struct {
    logic [2:0] cmd;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnStart, btnPause, btnReset;
  logic       startGame, pauseGame, resetGame;
  logic [2:0] btnLevel;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t e;

  game_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btnStart (btnStart),
    .btnPause (btnPause),
    .btnReset (btnReset),
    .startGame(startGame),
    .pauseGame(pauseGame),
    .resetGame(resetGame),
    .btnLevel (btnLevel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edge 1 is the next posedge after a negedge drive; pulse is seen after edge 7.
  task automatic expect_pulse(input logic [2:0] cmd, input int after_edges);
    exp_t x;
    x.cmd = cmd;
    x.cyc = cyc + after_edges;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if ({resetGame, pauseGame, startGame} != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, resetGame, pauseGame, startGame}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cmd", {29'd0, resetGame, pauseGame, startGame}, {29'd0, e.cmd});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    btnStart = 1'b1;
    btnPause = 1'b1;
    btnReset = 1'b1;

    // 1: reset state, then quiet after release
    wait_cycles(3);
    check("reset_outputs", {26'd0, startGame, pauseGame, resetGame, btnLevel}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {26'd0, startGame, pauseGame, resetGame, btnLevel}, 32'd0);
    end

    // 2: start press latency and no re-fire while held
    btnStart = 1'b0;
    expect_pulse(3'b001, 7);
    wait_cycles(5);
    check("start_level_pre", {29'd0, btnLevel}, 32'd0);
    wait_cycles(1);
    check("start_level", {29'd0, btnLevel}, 32'd1);
    wait_cycles(9);
    check("start_level_held", {29'd0, btnLevel}, 32'd1);
    btnStart = 1'b1;
    wait_cycles(12);
    check("start_released", {29'd0, btnLevel}, 32'd0);

    // 3: 3-cycle pause glitch is rejected
    btnPause = 1'b0;
    wait_cycles(3);
    btnPause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("glitch_level", {29'd0, btnLevel}, 32'd0);
    end

    // 4: simultaneous pause and reset -> reset wins, pause dropped
    btnPause = 1'b0;
    btnReset = 1'b0;
    expect_pulse(3'b100, 7);
    wait_cycles(10);
    check("both_level", {29'd0, btnLevel}, 32'b110);
    btnPause = 1'b1;
    btnReset = 1'b1;
    wait_cycles(12);
    check("both_released", {29'd0, btnLevel}, 32'd0);

    // 5: reset mid-debounce restarts the full window
    btnStart = 1'b0;
    wait_cycles(4);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {26'd0, startGame, pauseGame, resetGame, btnLevel}, 32'd0);
    wait_cycles(1);
    reset = 1'b0;
    expect_pulse(3'b001, 7);
    wait_cycles(5);
    check("midreset_level_pre", {29'd0, btnLevel}, 32'd0);
    wait_cycles(1);
    check("midreset_level", {29'd0, btnLevel}, 32'd1);
    wait_cycles(4);
    btnStart = 1'b1;
    wait_cycles(12);
    check("midreset_released", {29'd0, btnLevel}, 32'd0);

    // 6: 40-cycle start hold
    btnStart = 1'b0;
    expect_pulse(3'b001, 7);
`ifdef LONG_PRESS_RESET_EN
    expect_pulse(3'b100, 6 + LC);
`endif
    wait_cycles(40);
    check("long_level", {29'd0, btnLevel}, 32'd1);
    btnStart = 1'b1;
    wait_cycles(12);
    check("long_released", {29'd0, btnLevel}, 32'd0);

    wait_cycles(5);
    check("sb_pending", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
